// File: rtl/fft_peak_detect_if.sv
// FFT peak detector bus bundle.
// Sample stream and clear in, peak/energy results out.
interface fft_peak_detect_if #(
  parameter int N = 64
);
  localparam int W = $clog2(N);

  logic                 do_en;
  logic signed [15:0]   do_re;
  logic signed [15:0]   do_im;
  logic                 clear;
  logic                 peak_valid;
  logic [W-1:0]         peak_bin;
  logic [31:0]          peak_pow;
  logic [32+W-1:0]      frame_energy;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output do_en, do_re, do_im, clear,
    input  peak_valid, peak_bin, peak_pow,
    input  frame_energy, frame_err, busy
  );

  modport slave (
    input  do_en, do_re, do_im, clear,
    output peak_valid, peak_bin, peak_pow,
    output frame_energy, frame_err, busy
  );
endinterface

// File: rtl/fft_peak_detect.sv
// FFT frame peak-power search and energy sum.
// Products -> sum -> compare/accumulate -> publish.
module fft_peak_detect #(
  parameter int N       = 64,
  parameter int TIMEOUT = 1023,
  parameter int SKIP_DC = 0
) (
  input logic            clk,
  input logic            reset,
  fft_peak_detect_if.slave bus
);
  localparam int W  = $clog2(N);
  localparam int EW = 32 + W;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            abort;

  logic            accept;
  logic            kill;
  logic [W-1:0]    cur_bin;
  logic signed [31:0] rr_s;
  logic signed [31:0] ii_s;

  logic            s1_v_q;
  logic [W-1:0]    s1_bin_q;
  logic [31:0]     s1_rr_q;
  logic [31:0]     s1_ii_q;
  logic            s2_v_q;
  logic [W-1:0]    s2_bin_q;
  logic [31:0]     s2_pow_q;
  logic            fin_q;
  logic            last_in;

  logic [31:0]     pk_pow_q;
  logic [W-1:0]    pk_bin_q;
  logic [EW-1:0]   acc_q;
  logic            skip0;
  logic            is_init;
  logic            take;
  logic [31:0]     npk_pow;
  logic [W-1:0]    npk_bin;
  logic [EW-1:0]   nacc;

  logic            pv_q;
  logic            err_q;
  logic [W-1:0]    pb_q;
  logic [31:0]     pp_q;
  logic [EW-1:0]   fe_q;

  // clear beats a coincident sample
  assign accept  = bus.do_en & ~bus.clear;
  assign kill    = bus.clear | abort;
  assign cur_bin = (state_q == RECV) ? cnt_q : '0;
  assign rr_s    = bus.do_re * bus.do_re;
  assign ii_s    = bus.do_im * bus.do_im;
  assign last_in = s2_v_q && (s2_bin_q == W'(N - 1));

  // state, bin counter and idle timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // frame sequencing: bin numbering, timeout abort, clear
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RECV;
          cnt_d   = W'(1);
          tmo_d   = '0;
        end
      end
      RECV: begin
        if (accept) begin
          tmo_d = '0;
          if (cnt_q == W'(N - 1)) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      FLUSH: begin
        if (accept) begin
          state_d = RECV;
          cnt_d   = W'(1);
          tmo_d   = '0;
        end else if (fin_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      abort   = 1'b0;
    end
  end

  // pipeline valid bits; any abort empties the pipe
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q;
      fin_q  <= last_in;
    end
  end

  // pipeline data: squares, then their unsigned sum
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_bin_q <= '0;
      s1_rr_q  <= '0;
      s1_ii_q  <= '0;
      s2_bin_q <= '0;
      s2_pow_q <= '0;
    end else begin
      s1_bin_q <= cur_bin;
      s1_rr_q  <= rr_s;
      s1_ii_q  <= ii_s;
      s2_bin_q <= s1_bin_q;
      s2_pow_q <= s1_rr_q + s1_ii_q;
    end
  end

  // strict greater-than keeps the lowest bin on ties
  always_comb begin
    skip0   = (SKIP_DC != 0) && (s2_bin_q == '0);
    is_init = (s2_bin_q == W'((SKIP_DC != 0) ? 1 : 0));
    take    = !skip0 && (is_init || (s2_pow_q > pk_pow_q));
    npk_pow = take ? s2_pow_q : pk_pow_q;
    npk_bin = take ? s2_bin_q : pk_bin_q;
    nacc    = (s2_bin_q == '0) ? EW'(s2_pow_q)
                               : acc_q + EW'(s2_pow_q);
  end

  // running peak and energy of the frame in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      pk_pow_q <= '0;
      pk_bin_q <= '0;
      acc_q    <= '0;
    end else if (s2_v_q && !kill) begin
      pk_pow_q <= npk_pow;
      pk_bin_q <= npk_bin;
      acc_q    <= nacc;
    end
  end

  // publish results; held until the next full frame
  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q  <= 1'b0;
      err_q <= 1'b0;
      pb_q  <= '0;
      pp_q  <= '0;
      fe_q  <= '0;
    end else begin
      pv_q  <= fin_q && !bus.clear;
      err_q <= abort;
      if (fin_q && !bus.clear) begin
        pb_q <= pk_bin_q;
        pp_q <= pk_pow_q;
        fe_q <= acc_q;
      end
    end
  end

  assign bus.peak_valid   = pv_q;
  assign bus.frame_err    = err_q;
  assign bus.peak_bin     = pb_q;
  assign bus.peak_pow     = pp_q;
  assign bus.frame_energy = fe_q;
  assign bus.busy         = (state_q != IDLE) | s1_v_q | s2_v_q | fin_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect.
// Two instances: SKIP_DC=0 (a) and SKIP_DC=1 (b).
module tb_fft_peak_detect;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.N(N)) a ();
  fft_peak_detect_if #(.N(N)) b ();

  fft_peak_detect #(.N(N), .TIMEOUT(1023), .SKIP_DC(0)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave)
  );
  fft_peak_detect #(.N(N), .TIMEOUT(1023), .SKIP_DC(1)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  int checks = 0;
  int failures = 0;
  int cnum = 0;
  int last_edge = 0;

  int pv_n = 0;
  int fe_n = 0;
  int pvb_n = 0;
  int pv_edge [2];
  logic [5:0]  pv_bin [2];
  logic [31:0] pv_pow [2];
  logic [37:0] pv_en [2];
  int fe_edge = 0;
  logic [5:0]  pvb_bin;
  logic [31:0] pvb_pow;
  logic [37:0] pvb_en;

  logic signed [15:0] fre [N];
  logic signed [15:0] fim [N];

  always @(posedge clk) cnum <= cnum + 1;

  // capture result pulses
  always @(negedge clk) begin
    if (a.peak_valid === 1'b1) begin
      if (pv_n < 2) begin
        pv_edge[pv_n] = cnum;
        pv_bin[pv_n]  = a.peak_bin;
        pv_pow[pv_n]  = a.peak_pow;
        pv_en[pv_n]   = a.frame_energy;
      end
      pv_n++;
    end
    if (a.frame_err === 1'b1) begin
      fe_edge = cnum;
      fe_n++;
    end
    if (b.peak_valid === 1'b1) begin
      pvb_bin = b.peak_bin;
      pvb_pow = b.peak_pow;
      pvb_en  = b.frame_energy;
      pvb_n++;
    end
  end

  task automatic release_in();
    a.do_en = 0; a.do_re = 0; a.do_im = 0; a.clear = 0;
    b.do_en = 0; b.do_re = 0; b.do_im = 0; b.clear = 0;
  endtask

  task automatic step(input logic en, input logic signed [15:0] re,
                      input logic signed [15:0] im, input logic clr);
    a.do_en = en; a.do_re = re; a.do_im = im; a.clear = clr;
    b.do_en = en; b.do_re = re; b.do_im = im; b.clear = clr;
    @(negedge clk);
    if (en) last_edge = cnum;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic zero_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < N; i++) begin
      step(1, fre[i], fim[i], 0);
      if (gap && i < N - 1) step(0, 0, 0, 0);
    end
    release_in();
  endtask

  task automatic clr_mon();
    pv_n = 0;
    fe_n = 0;
    pvb_n = 0;
  endtask

  task automatic test_reset();
    checks++; if (a.peak_valid !== 1'b0) begin failures++; $display("FAIL rst_pv got=%0d exp=0", a.peak_valid); end
    checks++; if (a.frame_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0d exp=0", a.frame_err); end
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", a.busy); end
    checks++; if (a.peak_bin !== 6'd0) begin failures++; $display("FAIL rst_bin got=%0d exp=0", a.peak_bin); end
    checks++; if (a.peak_pow !== 32'd0) begin failures++; $display("FAIL rst_pow got=%0d exp=0", a.peak_pow); end
    checks++; if (a.frame_energy !== 38'd0) begin failures++; $display("FAIL rst_energy got=%0d exp=0", a.frame_energy); end
    clr_mon();
    zero_frame();
    fre[4] = 100;
    send_frame(0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(6);
    checks++; if (pv_n !== 0) begin failures++; $display("FAIL rst_pipe_pulse got=%0d exp=0", pv_n); end
    checks++; if (a.peak_pow !== 32'd0) begin failures++; $display("FAIL rst_pipe_pow got=%0d exp=0", a.peak_pow); end
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL rst_pipe_busy got=%0d exp=0", a.busy); end
  endtask

  task automatic test_single_tone();
    clr_mon();
    zero_frame();
    fre[5] = 1000;
    for (int i = 0; i < N; i++) begin
      step(1, fre[i], fim[i], 0);
      if (i == 10) begin
        checks++; if (a.busy !== 1'b1) begin failures++; $display("FAIL tone_busy got=%0d exp=1", a.busy); end
      end
    end
    release_in();
    idle(6);
    checks++; if (pv_n !== 1) begin failures++; $display("FAIL tone_pulses got=%0d exp=1", pv_n); end
    checks++; if (pv_edge[0] !== last_edge + 3) begin failures++; $display("FAIL tone_latency got=%0d exp=%0d", pv_edge[0], last_edge + 3); end
    checks++; if (pv_bin[0] !== 6'd5) begin failures++; $display("FAIL tone_bin got=%0d exp=5", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'd1000000) begin failures++; $display("FAIL tone_pow got=%0d exp=1000000", pv_pow[0]); end
    checks++; if (pv_en[0] !== 38'd1000000) begin failures++; $display("FAIL tone_energy got=%0d exp=1000000", pv_en[0]); end
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL tone_idle_busy got=%0d exp=0", a.busy); end
    checks++; if (a.peak_bin !== 6'd5) begin failures++; $display("FAIL tone_hold got=%0d exp=5", a.peak_bin); end
  endtask

  task automatic test_max_power();
    clr_mon();
    for (int i = 0; i < N; i++) begin
      fre[i] = -32768;
      fim[i] = -32768;
    end
    send_frame(0);
    idle(6);
    checks++; if (pv_n !== 1) begin failures++; $display("FAIL max_pulses got=%0d exp=1", pv_n); end
    checks++; if (pv_bin[0] !== 6'd0) begin failures++; $display("FAIL max_bin got=%0d exp=0", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'h8000_0000) begin failures++; $display("FAIL max_pow got=%0h exp=80000000", pv_pow[0]); end
    checks++; if (pv_en[0] !== 38'h20_0000_0000) begin failures++; $display("FAIL max_energy got=%0h exp=2000000000", pv_en[0]); end
  endtask

  task automatic test_skip_dc();
    clr_mon();
    zero_frame();
    fre[0] = 3000;
    fim[10] = -200;
    fim[20] = -200;
    send_frame(0);
    idle(6);
    checks++; if (pvb_n !== 1) begin failures++; $display("FAIL skip_pulses got=%0d exp=1", pvb_n); end
    checks++; if (pvb_bin !== 6'd10) begin failures++; $display("FAIL skip_bin got=%0d exp=10", pvb_bin); end
    checks++; if (pvb_pow !== 32'd40000) begin failures++; $display("FAIL skip_pow got=%0d exp=40000", pvb_pow); end
    checks++; if (pvb_en !== 38'd9080000) begin failures++; $display("FAIL skip_energy got=%0d exp=9080000", pvb_en); end
    checks++; if (pv_bin[0] !== 6'd0) begin failures++; $display("FAIL noskip_bin got=%0d exp=0", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'd9000000) begin failures++; $display("FAIL noskip_pow got=%0d exp=9000000", pv_pow[0]); end
  endtask

  task automatic test_gaps();
    clr_mon();
    zero_frame();
    fim[3] = 7;
    fre[60] = -7;
    send_frame(1);
    idle(6);
    checks++; if (pv_n !== 1) begin failures++; $display("FAIL gap_pulses got=%0d exp=1", pv_n); end
    checks++; if (pv_edge[0] !== last_edge + 3) begin failures++; $display("FAIL gap_latency got=%0d exp=%0d", pv_edge[0], last_edge + 3); end
    checks++; if (pv_bin[0] !== 6'd3) begin failures++; $display("FAIL gap_tie_bin got=%0d exp=3", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'd49) begin failures++; $display("FAIL gap_pow got=%0d exp=49", pv_pow[0]); end
    checks++; if (pv_en[0] !== 38'd98) begin failures++; $display("FAIL gap_energy got=%0d exp=98", pv_en[0]); end
  endtask

  task automatic test_back_to_back();
    int e1;
    logic signed [15:0] re;
    logic signed [15:0] im;
    e1 = 0;
    clr_mon();
    for (int i = 0; i < 2 * N; i++) begin
      re = (i == 7) ? 16'sd500 : ((i == 127) ? -16'sd100 : 16'sd0);
      im = (i == 7) ? 16'sd500 : 16'sd0;
      step(1, re, im, 0);
      if (i == N - 1) e1 = last_edge;
    end
    release_in();
    idle(6);
    checks++; if (pv_n !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pv_n); end
    checks++; if (pv_edge[0] !== e1 + 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", pv_edge[0], e1 + 3); end
    checks++; if (pv_edge[1] - pv_edge[0] !== 64) begin failures++; $display("FAIL b2b_spacing got=%0d exp=64", pv_edge[1] - pv_edge[0]); end
    checks++; if (pv_bin[0] !== 6'd7) begin failures++; $display("FAIL b2b_bin1 got=%0d exp=7", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'd500000) begin failures++; $display("FAIL b2b_pow1 got=%0d exp=500000", pv_pow[0]); end
    checks++; if (pv_en[0] !== 38'd500000) begin failures++; $display("FAIL b2b_energy1 got=%0d exp=500000", pv_en[0]); end
    checks++; if (pv_bin[1] !== 6'd63) begin failures++; $display("FAIL b2b_bin2 got=%0d exp=63", pv_bin[1]); end
    checks++; if (pv_pow[1] !== 32'd10000) begin failures++; $display("FAIL b2b_pow2 got=%0d exp=10000", pv_pow[1]); end
    checks++; if (pv_en[1] !== 38'd10000) begin failures++; $display("FAIL b2b_energy2 got=%0d exp=10000", pv_en[1]); end
  endtask

  task automatic test_timeout();
    int l;
    clr_mon();
    for (int i = 0; i < 30; i++) step(1, 20, 0, 0);
    l = last_edge;
    release_in();
    idle(1030);
    checks++; if (fe_n !== 1) begin failures++; $display("FAIL tmo_err_pulses got=%0d exp=1", fe_n); end
    checks++; if (fe_edge !== l + 1023) begin failures++; $display("FAIL tmo_err_edge got=%0d exp=%0d", fe_edge, l + 1023); end
    checks++; if (pv_n !== 0) begin failures++; $display("FAIL tmo_no_pv got=%0d exp=0", pv_n); end
    checks++; if (a.peak_bin !== 6'd63) begin failures++; $display("FAIL tmo_hold_bin got=%0d exp=63", a.peak_bin); end
    checks++; if (a.peak_pow !== 32'd10000) begin failures++; $display("FAIL tmo_hold_pow got=%0d exp=10000", a.peak_pow); end
    checks++; if (a.frame_energy !== 38'd10000) begin failures++; $display("FAIL tmo_hold_energy got=%0d exp=10000", a.frame_energy); end
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%0d exp=0", a.busy); end
    zero_frame();
    fim[9] = 300;
    send_frame(0);
    idle(6);
    checks++; if (pv_n !== 1) begin failures++; $display("FAIL tmo_next_pulses got=%0d exp=1", pv_n); end
    checks++; if (pv_bin[0] !== 6'd9) begin failures++; $display("FAIL tmo_next_bin got=%0d exp=9", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'd90000) begin failures++; $display("FAIL tmo_next_pow got=%0d exp=90000", pv_pow[0]); end
    checks++; if (pv_en[0] !== 38'd90000) begin failures++; $display("FAIL tmo_next_energy got=%0d exp=90000", pv_en[0]); end
  endtask

  task automatic test_clear_reset();
    clr_mon();
    for (int i = 0; i < 40; i++) step(1, 20, 0, 0);
    step(1, 20, 0, 1);
    release_in();
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%0d exp=0", a.busy); end
    checks++; if (a.peak_pow !== 32'd90000) begin failures++; $display("FAIL clr_hold_pow got=%0d exp=90000", a.peak_pow); end
    for (int i = 0; i < 20; i++) step(1, 20, 0, 0);
    reset = 1'b1;
    step(1, 20, 0, 0);
    reset = 1'b0;
    release_in();
    idle(6);
    checks++; if (pv_n !== 0) begin failures++; $display("FAIL clr_no_pv got=%0d exp=0", pv_n); end
    checks++; if (fe_n !== 0) begin failures++; $display("FAIL clr_no_err got=%0d exp=0", fe_n); end
    checks++; if (a.busy !== 1'b0) begin failures++; $display("FAIL clr_rst_busy got=%0d exp=0", a.busy); end
    checks++; if (a.peak_pow !== 32'd0) begin failures++; $display("FAIL clr_rst_pow got=%0d exp=0", a.peak_pow); end
    zero_frame();
    fre[33] = -5;
    fim[33] = -12;
    send_frame(0);
    idle(6);
    checks++; if (pv_n !== 1) begin failures++; $display("FAIL clr_next_pulses got=%0d exp=1", pv_n); end
    checks++; if (pv_bin[0] !== 6'd33) begin failures++; $display("FAIL clr_next_bin got=%0d exp=33", pv_bin[0]); end
    checks++; if (pv_pow[0] !== 32'd169) begin failures++; $display("FAIL clr_next_pow got=%0d exp=169", pv_pow[0]); end
    checks++; if (pv_en[0] !== 38'd169) begin failures++; $display("FAIL clr_next_energy got=%0d exp=169", pv_en[0]); end
  endtask

  initial begin
    reset = 1'b1;
    release_in();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_tone();
    test_max_power();
    test_skip_dc();
    test_gaps();
    test_back_to_back();
    test_timeout();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter N, default 64, frame length in bins (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 1023, idle cycles allowed mid-frame before abort.
REQ-003 SHALL have parameter SKIP_DC, default 0; 1 excludes bin 0 from the peak search only.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port do_en  in  1  FFT output sample valid.
REQ-007 SHALL have port do_re  in  16  signed real part of the bin.
REQ-008 SHALL have port do_im  in  16  signed imaginary part of the bin.
REQ-009 SHALL have port clear  in  1  synchronous abort of the current frame.
REQ-010 SHALL have port peak_valid  out  1  one-cycle result pulse.
REQ-011 SHALL have port peak_bin  out  log2(N)  index of the maximum-power bin.
REQ-012 SHALL have port peak_pow  out  32  unsigned power of the peak bin.
REQ-013 SHALL have port frame_energy  out  32+log2(N)  unsigned sum of power over all N bins.
REQ-014 SHALL have port frame_err  out  1  one-cycle timeout-abort pulse.
REQ-015 SHALL have port busy  out  1  high while a frame is partially received or in the pipeline.

Function
REQ-016 SHALL assign bin index by arrival order: the first do_en after reset, clear, abort or frame completion is bin 0; each later do_en adds one; the N-th is bin N-1.
REQ-017 SHALL compute the power as re*re + im*im: signed 16x16 products, summed unsigned 32-bit; (-32768,-32768) gives 0x80000000 with no overflow.
REQ-018 SHALL use a 2-stage pipeline (products, then sum), then do compare/accumulate in the following cycle.
REQ-019 SHALL drive peak_valid on the 3rd rising edge after the edge that samples the N-th do_en.
REQ-020 SHALL update the peak only when the power is strictly greater than the current peak; a tie keeps the lowest bin index.
REQ-021 SHALL, with SKIP_DC=1, include bin 0 in frame_energy but never select it as the peak; peak_bin/peak_pow then init from bin 1.
REQ-022 SHALL accept gaps in do_en: bins are counted only on do_en and the timing is otherwise unaffected.
REQ-023 SHALL support back-to-back frames with do_en continuously high; bin 0 of the next frame starts a fresh peak/energy without losing or merging samples.
REQ-024 SHALL use states IDLE (no samples held), RECV (1..N-1 bins taken) and FLUSH (N-th bin in pipeline, no new frame started).
REQ-025 SHALL transition IDLE->RECV on do_en and RECV->FLUSH on the N-th do_en.
REQ-026 SHALL transition FLUSH->IDLE at peak_valid, or FLUSH->RECV if a new do_en occurred during FLUSH.
REQ-027 SHALL run the timeout only in RECV: the counter resets on each do_en; TIMEOUT consecutive cycles without do_en pulse frame_err, discard the partial frame, go to IDLE, and emit no peak_valid.
REQ-028 SHALL, on clear, discard all partial and in-pipeline data, go to IDLE and emit no pulse; clear wins over a do_en in the same cycle, and that sample is dropped.
REQ-029 SHALL hold peak_bin, peak_pow and frame_energy stable from one peak_valid until the next; they are not altered by clear, frame_err or a partial frame.
REQ-030 SHALL drive busy high in RECV/FLUSH, or while any pipeline stage holds valid data.

Reset
REQ-031 SHALL, on reset high at a clock edge, set every output to 0, the state to IDLE, the bin counter to 0 and the timeout counter to 0.
REQ-032 SHALL drop in-flight samples on reset mid-frame or mid-pipeline and emit no pulse.

Verification
REQ-033 SHALL cover: bin 5 = (1000,0), other bins 0 -> peak_valid 3 cycles after the last do_en, peak_bin=5, peak_pow=1000000, frame_energy=1000000.
REQ-034 SHALL cover: all 64 bins (-32768,-32768) -> peak_pow=0x80000000, peak_bin=0 (tie), frame_energy=2^37.
REQ-035 SHALL cover: SKIP_DC=1, bin0=(3000,0), bins 10 and 20 = (0,-200) -> peak_bin=10, peak_pow=40000, frame_energy=9080000.
REQ-036 SHALL cover: 128 continuous do_en cycles, frame1 tone at bin 7 (500,500), frame2 at bin 63 (-100,0) -> two pulses 64 cycles apart with (7,500000) then (63,10000).
REQ-037 SHALL cover: 30 samples, then do_en low for 1023 cycles -> one frame_err pulse, no peak_valid, outputs unchanged; the next full frame is correct from bin 0.
REQ-038 SHALL cover: clear together with do_en at bin 40, then reset at bin 20 of a new frame -> no pulses, busy=0; a following full frame is correct.
